// File: rtl/vga_pkg.sv
// Character widths and codes shared by the VGA text pipeline.
// Latency: none (constants only).
// Backpressure: none.
package vga_pkg;

  localparam int CHAR_W = 7;

  typedef logic [CHAR_W-1:0] char_t;

  localparam char_t SPACE  = 7'h20;
  localparam char_t CHAR_A = 7'h41;
  localparam char_t CHAR_B = 7'h42;
  localparam char_t CHAR_C = 7'h43;

endpackage

// File: rtl/text_page_ram.sv
// Simple dual-port character store: one write port, one synchronous read port.
// Latency: read data valid one cycle after the read address is sampled.
// Backpressure: none; a write is taken every cycle i_we is high.
module text_page_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: no reset on the array, contents are initialised by the owner's clear sweep.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered, so a same-cycle write to the read address returns the old data.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/game_text_page.sv
// Text page buffer with clear sweep and typewriter-style progressive reveal.
// Latency: char_code follows char_xy by exactly one cycle.
// Backpressure: wr_ready low during clear, reset, and in any cycle clr_req is high.
module game_text_page
  import vga_pkg::*;
#(
  parameter  int COLS       = 16,
  parameter  int ROWS       = 4,
  parameter  int REVEAL_DIV = 4,
  localparam int COL_W      = $clog2(COLS),
  localparam int ROW_W      = $clog2(ROWS),
  localparam int AW         = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     char_xy,
  output logic [CHAR_W-1:0] char_code,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy,
  input  logic              frame_tick,
  input  logic              reveal_en,
  input  logic              reveal_restart,
  output logic              reveal_done
);

  localparam int N     = ROWS * COLS;
  localparam int LIN_W = $clog2(N);
  localparam int RC_W  = $clog2(N + 1);
  localparam int DC_W  = $clog2(REVEAL_DIV + 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LIN_W-1:0]   r_clr_addr;
  logic [RC_W-1:0]    r_rcnt;
  logic [DC_W-1:0]    r_dcnt;
  logic               r_done;
  logic               r_rd_blank;

  logic               w_clearing;
  logic               w_clr_last;
  logic               w_idle_ready;
  logic               w_wr_fire;

  logic [ROW_W-1:0]   w_rd_row;
  logic [COL_W-1:0]   w_rd_col;
  logic               w_rd_in_range;
  logic [LIN_W-1:0]   w_rd_lin;
  logic [ROW_W-1:0]   w_wr_row;
  logic [COL_W-1:0]   w_wr_col;
  logic               w_wr_in_range;
  logic [LIN_W-1:0]   w_wr_lin;

  logic               w_ram_we;
  logic [LIN_W-1:0]   w_ram_waddr;
  logic [CHAR_W-1:0]  w_ram_wdata;
  logic [CHAR_W-1:0]  w_ram_q;

  // Address decode: {row, col} to linear index; out-of-range cells map to 0 and are masked/dropped.
  assign w_rd_row      = char_xy[AW-1:COL_W];
  assign w_rd_col      = char_xy[COL_W-1:0];
  assign w_rd_in_range = (int'(w_rd_row) < ROWS) && (int'(w_rd_col) < COLS);
  assign w_rd_lin      = w_rd_in_range ? LIN_W'(int'(w_rd_row) * COLS + int'(w_rd_col)) : '0;

  assign w_wr_row      = wr_addr[AW-1:COL_W];
  assign w_wr_col      = wr_addr[COL_W-1:0];
  assign w_wr_in_range = (int'(w_wr_row) < ROWS) && (int'(w_wr_col) < COLS);
  assign w_wr_lin      = w_wr_in_range ? LIN_W'(int'(w_wr_row) * COLS + int'(w_wr_col)) : '0;

  // State register; reset lands in CLEAR so the array is swept without its own reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; a clear request beats a simultaneous write.
  always_comb begin
    w_state_nxt  = r_state;
    w_clearing   = 1'b0;
    w_clr_last   = 1'b0;
    w_idle_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle_ready = !clr_req;
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clearing = 1'b1;
        w_clr_last = (r_clr_addr == LIN_W'(N - 1));
        if (w_clr_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign wr_ready  = w_idle_ready && !rst;
  assign busy      = w_clearing || rst;
  assign w_wr_fire = wr_valid && wr_ready;

  // Clear sweep address: held at 0 outside CLEAR so every sweep starts from the first cell.
  always_ff @(posedge clk) begin
    if (rst || !w_clearing || w_clr_last) begin
      r_clr_addr <= '0;
    end else begin
      r_clr_addr <= r_clr_addr + LIN_W'(1);
    end
  end

  // Reveal divider and character counter; restart and end of clear both rewind to index 0.
  always_ff @(posedge clk) begin
    if (rst || reveal_restart || w_clr_last) begin
      r_rcnt <= '0;
      r_dcnt <= '0;
    end else if (frame_tick) begin
      if (r_dcnt == DC_W'(REVEAL_DIV - 1)) begin
        r_dcnt <= '0;
        if (r_rcnt != RC_W'(N)) begin
          r_rcnt <= r_rcnt + RC_W'(1);
        end
      end else begin
        r_dcnt <= r_dcnt + DC_W'(1);
      end
    end
  end

  // Completion flag, registered off the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_rcnt == RC_W'(N));
    end
  end

  // Blanking decision sampled alongside the RAM read so both line up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_blank <= 1'b1;
    end else begin
      r_rd_blank <= w_clearing || !w_rd_in_range ||
                    (reveal_en && (RC_W'(w_rd_lin) >= r_rcnt));
    end
  end

  assign w_ram_we    = w_clearing || (w_wr_fire && w_wr_in_range);
  assign w_ram_waddr = w_clearing ? r_clr_addr : w_wr_lin;
  assign w_ram_wdata = w_clearing ? SPACE : wr_data;

  text_page_ram #(
    .DEPTH  (N),
    .ADDR_W (LIN_W),
    .DATA_W (CHAR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_rd_lin),
    .o_rdata (w_ram_q)
  );

  assign char_code   = r_rd_blank ? SPACE : w_ram_q;
  assign reveal_done = r_done;

endmodule

// File: tb/tb_game_text_page.sv
// Self-checking bench for game_text_page: reference page model plus directed and random stimulus.
// Latency: expects char_code one cycle after char_xy.
// Backpressure: writes are only modelled as taken when no clear or reset is in progress.
`timescale 1ns/1ps
module tb_game_text_page;
  import vga_pkg::*;

  localparam int COLS  = 16;
  localparam int ROWS  = 4;
  localparam int DIV   = 4;
  localparam int COL_W = 4;
  localparam int AW    = 6;
  localparam int N     = ROWS * COLS;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (16 x 4)
  logic          rst = 1'b1;
  logic [AW-1:0] char_xy = '0;
  logic [6:0]    char_code;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [6:0]    wr_data = '0;
  logic          clr_req = 1'b0;
  logic          busy;
  logic          frame_tick = 1'b0;
  logic          reveal_en = 1'b0;
  logic          reveal_restart = 1'b0;
  logic          reveal_done;

  // second instance (10 x 4) for out-of-range columns
  logic          d2_rst = 1'b1;
  logic [5:0]    d2_char_xy = '0;
  logic [6:0]    d2_char_code;
  logic          d2_wr_valid = 1'b0;
  logic          d2_wr_ready;
  logic [5:0]    d2_wr_addr = '0;
  logic [6:0]    d2_wr_data = '0;
  logic          d2_busy;
  logic          d2_reveal_done;

  game_text_page #(.COLS(COLS), .ROWS(ROWS), .REVEAL_DIV(DIV)) u_dut (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(char_code),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .frame_tick(frame_tick), .reveal_en(reveal_en),
    .reveal_restart(reveal_restart), .reveal_done(reveal_done)
  );

  game_text_page #(.COLS(10), .ROWS(4), .REVEAL_DIV(DIV)) u_dut2 (
    .clk(clk), .rst(d2_rst), .char_xy(d2_char_xy), .char_code(d2_char_code),
    .wr_valid(d2_wr_valid), .wr_ready(d2_wr_ready), .wr_addr(d2_wr_addr), .wr_data(d2_wr_data),
    .clr_req(1'b0), .busy(d2_busy), .frame_tick(1'b0), .reveal_en(1'b0),
    .reveal_restart(1'b0), .reveal_done(d2_reveal_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reference model ----------------
  // Page contents, remaining clear cycles, and frame ticks seen since the last rewind;
  // revealed count is simply ticks / DIV, saturated at N.
  logic [6:0] m_page [N];
  int         m_clear_left = 0;
  int         m_ticks = 0;
  bit         m_valid = 1'b0;
  logic [6:0] exp_code;
  logic       exp_done;

  always @(posedge clk) begin : model
    int rc;
    int ri;
    bit was_busy;
    rc = m_ticks / DIV;
    if (rc > N) rc = N;
    was_busy = (m_clear_left > 0);
    if (rst) begin
      m_valid      = 1'b1;
      m_clear_left = N;
      m_ticks      = 0;
      exp_code     = SPACE;
      exp_done     = 1'b0;
      foreach (m_page[i]) m_page[i] = SPACE;
    end else begin
      ri = int'(char_xy[AW-1:COL_W]) * COLS + int'(char_xy[COL_W-1:0]);
      exp_code = (was_busy || (reveal_en && ri >= rc)) ? SPACE : m_page[ri];
      exp_done = (rc == N);
      if (was_busy) m_clear_left--;
      if ((was_busy && m_clear_left == 0) || reveal_restart) m_ticks = 0;
      else if (frame_tick && m_ticks < N * DIV) m_ticks++;
      if (!was_busy) begin
        if (clr_req) begin
          m_clear_left = N;
          foreach (m_page[i]) m_page[i] = SPACE;
        end else if (wr_valid) begin
          m_page[int'(wr_addr[AW-1:COL_W]) * COLS + int'(wr_addr[COL_W-1:0])] = wr_data;
        end
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic eb;
      eb = rst || (m_clear_left > 0);
      chk("char_code", char_code, exp_code);
      chk("busy", busy, eb);
      chk("wr_ready", wr_ready, !eb && !clr_req);
      chk("reveal_done", reveal_done, exp_done);
    end
  end

  task automatic rd(input logic [AW-1:0] a, input logic [6:0] e, input string nm);
    char_xy = a;
    step();
    chk(nm, char_code, e);
  endtask

  task automatic d2_rd(input logic [5:0] a, input logic [6:0] e, input string nm);
    d2_char_xy = a;
    step();
    chk(nm, d2_char_code, e);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    d2_rst = 1'b1;
    step(3);
    chk("reset_busy", busy, 1'b1);
    chk("reset_wr_ready", wr_ready, 1'b0);
    chk("reset_char_code", char_code, SPACE);
    chk("reset_reveal_done", reveal_done, 1'b0);
    rst = 1'b0;
    d2_rst = 1'b0;
    count_busy(n);
    chk("busy_cycles_after_reset", n, N);

    for (int i = 0; i < N; i++) rd(AW'(i), SPACE, "cleared_read");

    // write then read, including the same-cycle read of the old contents
    chk("idle_wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_addr = 6'h21; wr_data = CHAR_C; char_xy = 6'h21;
    step();
    wr_valid = 1'b0;
    chk("same_cycle_read_old", char_code, SPACE);
    step();
    chk("read_after_write", char_code, CHAR_C);

    // clear beats a simultaneous write
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 6'h05; wr_data = CHAR_A;
    @(negedge clk);
    chk("wr_ready_vs_clr_req", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    clr_req = 1'b0; wr_valid = 1'b0;
    count_busy(n);
    chk("busy_cycles_clear", n, N);
    rd(6'h05, SPACE, "write_lost_to_clear");
    rd(6'h21, SPACE, "cell_cleared");

    // typewriter reveal
    for (int i = 0; i < N; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = CHAR_A;
      step();
    end
    wr_valid = 1'b0;
    reveal_en = 1'b1; reveal_restart = 1'b1;
    step();
    reveal_restart = 1'b0;
    tick_n(8);
    rd(6'd0, CHAR_A, "reveal_idx0");
    rd(6'd1, CHAR_A, "reveal_idx1");
    rd(6'd2, SPACE, "reveal_idx2_hidden");
    tick_n(247);
    rd(6'd62, CHAR_A, "reveal_idx62");
    rd(6'd63, SPACE, "reveal_idx63_hidden");
    chk("reveal_not_done_255", reveal_done, 1'b0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("reveal_done_256", reveal_done, 1'b1);
    tick_n(20);
    chk("reveal_done_sticks", reveal_done, 1'b1);
    rd(6'd63, CHAR_A, "reveal_idx63_shown");

    // reset in the middle of a clear restarts the full sweep
    reveal_en = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    chk("busy_after_midclear_reset", n, N);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      wr_valid       = 1'($urandom_range(0, 1));
      wr_addr        = AW'($urandom);
      wr_data        = 7'($urandom);
      char_xy        = AW'($urandom);
      frame_tick     = ($urandom_range(0, 1) == 0);
      reveal_restart = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) reveal_en = ~reveal_en;
      clr_req        = ($urandom_range(0, 299) == 0);
      rst            = ($urandom_range(0, 999) == 0);
      step();
    end
    wr_valid = 1'b0; frame_tick = 1'b0; reveal_restart = 1'b0; clr_req = 1'b0; rst = 1'b0;
    step(70);

    // narrow page: columns 10..15 do not exist
    n = 0;
    while (d2_busy && n < 200) begin
      step();
      n++;
    end
    chk("d2_idle", d2_busy, 1'b0);
    d2_wr_valid = 1'b1; d2_wr_addr = {2'd0, 4'd12}; d2_wr_data = CHAR_A;
    chk("d2_oob_wr_ready", d2_wr_ready, 1'b1);
    step();
    d2_wr_valid = 1'b0;
    d2_rd({2'd0, 4'd12}, SPACE, "d2_oob_read");
    d2_rd({2'd1, 4'd2}, SPACE, "d2_no_alias");
    d2_wr_valid = 1'b1; d2_wr_addr = {2'd1, 4'd2}; d2_wr_data = CHAR_B;
    step();
    d2_wr_valid = 1'b0;
    d2_rd({2'd1, 4'd2}, CHAR_B, "d2_inrange_read");
    d2_wr_valid = 1'b1; d2_wr_addr = {2'd3, 4'd9}; d2_wr_data = CHAR_A;
    step();
    d2_wr_valid = 1'b0;
    d2_rd({2'd3, 4'd9}, CHAR_A, "d2_last_cell");
    d2_rd({2'd3, 4'd12}, SPACE, "d2_oob_read_row3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
